rom_bus_sequencer: RTL and testbench

//  Memory-side responder for decoded SNES/MCU accesses: takes a byte request (addr already

---
 rtl/rom_seq_pkg.sv | 33 +++
 rtl/rom_seq_timer.sv | 35 +++
 rtl/rom_bus_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_rom_bus_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg
//   Shared types and helpers for the ROM bus sequencer.
//   - seq_state_t : bus-cycle FSM states (IDLE/SETUP/STROBE/HOLD)
//   - master_t    : which requester owns the current bus cycle
//   - LANE_LO/HI  : value of addr[0] selecting the low/high byte lane
//   - cnt_width() : bits needed to hold a cycle count
//   Optional feature in the top level: SNES_READ_CACHE_EN.
package rom_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } seq_state_t;

  typedef enum logic {
    MST_SNES = 1'b0,
    MST_MCU  = 1'b1
  } master_t;

  localparam logic LANE_LO = 1'b0;  // addr[0]=0 -> ROM_DATA[7:0],  BLE_N
  localparam logic LANE_HI = 1'b1;  // addr[0]=1 -> ROM_DATA[15:8], BHE_N

  // Smallest width (>=1) able to represent max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/rom_seq_timer.sv
// rom_seq_timer
//   Loadable down-counter used to time the STROBE and HOLD phases.
//   Loading value N makes o_done rise N cycles later (N=0 -> done on the
//   first cycle after the load).
// Ports
//   i_clk    in  clock
//   i_rst_n  in  async active-low reset (count cleared)
//   i_load   in  load i_value into the counter
//   i_value  in  CW-bit load value
//   o_done   out counter is at zero
module rom_seq_timer #(
  parameter int CW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_value,
  output logic          o_done
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/rom_bus_sequencer.sv
// rom_bus_sequencer
//   Memory-side responder for decoded SNES / MCU byte accesses. Each request
//   runs one timed cycle on the 16-bit PSRAM ROM bus:
//     IDLE -> SETUP (1 cycle) -> STROBE (RD_CYCLES / WR_CYCLES)
//          -> HOLD (HOLD_CYCLES, skipped when 0) -> IDLE
//   SNES has priority; the MCU is never starved by back-to-back SNES traffic.
//   Read latency req->rdy is 2+RD_CYCLES, write latency 2+WR_CYCLES.
// Ports
//   CLK, RST_N                      clock, async active-low reset
//   snes_req/we/addr/wdata          SNES request (1-cycle pulse)
//   snes_rdata/rdy                  SNES read byte / completion pulse
//   snes_ovf                        sticky: SNES request seen while one pending
//   mcu_req/we/addr/wdata           MCU request (1-cycle pulse)
//   mcu_rdata/rdy                   MCU read byte / completion pulse
//   ROM_ADDR                        word address (addr[23:1])
//   ROM_DATA_IN/OUT, ROM_DATA_OE    bus data in / out (byte replicated) / drive
//   ROM_CE_N, ROM_OE_N, ROM_WE_N    strobes
//   ROM_BHE_N, ROM_BLE_N            byte lane enables
// Configuration
//   SNES_READ_CACHE_EN : one-word buffer of the last SNES read; hitting SNES
//   reads complete the next cycle without a bus cycle.
module rom_bus_sequencer
  import rom_seq_pkg::*;
#(
  parameter int RD_CYCLES   = 4,
  parameter int WR_CYCLES   = 5,
  parameter int HOLD_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        snes_req,
  input  logic        snes_we,
  input  logic [23:0] snes_addr,
  input  logic [7:0]  snes_wdata,
  output logic [7:0]  snes_rdata,
  output logic        snes_rdy,
  output logic        snes_ovf,
  input  logic        mcu_req,
  input  logic        mcu_we,
  input  logic [23:0] mcu_addr,
  input  logic [7:0]  mcu_wdata,
  output logic [7:0]  mcu_rdata,
  output logic        mcu_rdy,
  output logic [22:0] ROM_ADDR,
  input  logic [15:0] ROM_DATA_IN,
  output logic [15:0] ROM_DATA_OUT,
  output logic        ROM_DATA_OE,
  output logic        ROM_CE_N,
  output logic        ROM_OE_N,
  output logic        ROM_WE_N,
  output logic        ROM_BHE_N,
  output logic        ROM_BLE_N
);

  localparam int MAX_RW = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int MAX_C  = (MAX_RW > HOLD_CYCLES) ? MAX_RW : HOLD_CYCLES;
  localparam int CW     = cnt_width(MAX_C);
  localparam logic [CW-1:0] RD_LOAD   = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LOAD   = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

  seq_state_t r_state, w_state_next;

  // Per-master pending request; the pending flag stays set until that
  // master's rdy is issued, so it also covers the in-service period.
  logic        r_snes_pend, r_snes_we;
  logic [23:0] r_snes_addr;
  logic [7:0]  r_snes_wdata;
  logic        r_mcu_pend, r_mcu_we;
  logic [23:0] r_mcu_addr;
  logic [7:0]  r_mcu_wdata;

  // Request currently on the bus
  master_t     r_cur_master;
  logic        r_cur_we;
  logic [23:0] r_cur_addr;
  logic [7:0]  r_cur_wdata;
  logic        r_last_snes;

  logic [7:0]  r_snes_rdata, r_mcu_rdata;
  logic        r_snes_rdy, r_mcu_rdy, r_snes_ovf;

  logic          w_tmr_load, w_tmr_done;
  logic [CW-1:0] w_tmr_val;
  logic          w_done, w_snes_hit;
  logic          w_snes_accept, w_mcu_accept, w_snes_want, w_mcu_want;
  logic          w_pick_mcu, w_grant;
  logic          w_sel_we;
  logic [23:0]   w_sel_addr;
  logic [7:0]    w_sel_wdata, w_rd_byte;

  rom_seq_timer #(.CW(CW)) u_timer (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  // Last STROBE cycle: data is sampled and the owner's rdy fires next cycle.
  assign w_done    = (r_state == ST_STROBE) && w_tmr_done;
  assign w_rd_byte = (r_cur_addr[0] == LANE_HI) ? ROM_DATA_IN[15:8] : ROM_DATA_IN[7:0];

`ifdef SNES_READ_CACHE_EN
  logic        r_cache_valid;
  logic [22:0] r_cache_tag;
  logic [15:0] r_cache_data;
  logic [7:0]  w_cache_byte;

  assign w_snes_hit   = snes_req && !snes_we && !r_snes_pend && r_cache_valid
                        && (r_cache_tag == snes_addr[23:1]);
  assign w_cache_byte = (snes_addr[0] == LANE_HI) ? r_cache_data[15:8] : r_cache_data[7:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cache_valid <= 1'b0;
      r_cache_tag   <= '0;
      r_cache_data  <= '0;
    end else if (w_done && !r_cur_we && (r_cur_master == MST_SNES)) begin
      r_cache_valid <= 1'b1;
      r_cache_tag   <= r_cur_addr[23:1];
      r_cache_data  <= ROM_DATA_IN;
    end else if (w_done && r_cur_we && r_cache_valid && (r_cache_tag == r_cur_addr[23:1])) begin
      // Keep the buffered word coherent with writes from either master.
      if (r_cur_addr[0] == LANE_HI) r_cache_data[15:8] <= r_cur_wdata;
      else                          r_cache_data[7:0]  <= r_cur_wdata;
    end
  end
`else
  assign w_snes_hit = 1'b0;
`endif

  // A request arriving while IDLE is granted in the same cycle so the
  // SETUP phase follows the req pulse directly.
  assign w_snes_accept = snes_req && !r_snes_pend && !w_snes_hit;
  assign w_mcu_accept  = mcu_req && (!r_mcu_pend || (w_done && (r_cur_master == MST_MCU)));
  assign w_snes_want   = r_snes_pend || w_snes_accept;
  assign w_mcu_want    = r_mcu_pend || w_mcu_accept;
  // SNES wins unless the last grant went to SNES while the MCU was already
  // waiting; this alternates under sustained contention.
  assign w_pick_mcu    = w_mcu_want && (!w_snes_want || (r_last_snes && r_mcu_pend));

  always_comb begin
    if (w_pick_mcu) begin
      w_sel_we    = r_mcu_pend ? r_mcu_we    : mcu_we;
      w_sel_addr  = r_mcu_pend ? r_mcu_addr  : mcu_addr;
      w_sel_wdata = r_mcu_pend ? r_mcu_wdata : mcu_wdata;
    end else begin
      w_sel_we    = r_snes_pend ? r_snes_we    : snes_we;
      w_sel_addr  = r_snes_pend ? r_snes_addr  : snes_addr;
      w_sel_wdata = r_snes_pend ? r_snes_wdata : snes_wdata;
    end
  end

  // Next state and bus strobes; strobes derive from the registered state so
  // an async reset releases them immediately.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    ROM_CE_N     = 1'b1;
    ROM_OE_N     = 1'b1;
    ROM_WE_N     = 1'b1;
    ROM_BHE_N    = 1'b1;
    ROM_BLE_N    = 1'b1;
    ROM_DATA_OE  = 1'b0;
    if ((r_state == ST_SETUP) || (r_state == ST_STROBE)) begin
      ROM_CE_N    = 1'b0;
      ROM_DATA_OE = r_cur_we;
      if (!r_cur_we) begin
        ROM_BHE_N = 1'b0;
        ROM_BLE_N = 1'b0;
      end else if (r_cur_addr[0] == LANE_HI) begin
        ROM_BHE_N = 1'b0;
      end else begin
        ROM_BLE_N = 1'b0;
      end
    end
    case (r_state)
      ST_IDLE: begin
        if (w_snes_want || w_mcu_want) begin
          w_grant      = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_tmr_load   = 1'b1;
        w_tmr_val    = r_cur_we ? WR_LOAD : RD_LOAD;
        w_state_next = ST_STROBE;
      end
      ST_STROBE: begin
        ROM_OE_N = r_cur_we;
        ROM_WE_N = !r_cur_we;
        if (w_tmr_done) begin
          if (HOLD_CYCLES > 0) begin
            w_tmr_load   = 1'b1;
            w_tmr_val    = HOLD_LOAD;
            w_state_next = ST_HOLD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (w_tmr_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_snes_pend  <= 1'b0;
      r_snes_we    <= 1'b0;
      r_snes_addr  <= '0;
      r_snes_wdata <= '0;
      r_snes_ovf   <= 1'b0;
      r_mcu_pend   <= 1'b0;
      r_mcu_we     <= 1'b0;
      r_mcu_addr   <= '0;
      r_mcu_wdata  <= '0;
    end else begin
      if (snes_req && r_snes_pend) r_snes_ovf <= 1'b1;
      if (w_snes_accept) begin
        r_snes_pend  <= 1'b1;
        r_snes_we    <= snes_we;
        r_snes_addr  <= snes_addr;
        r_snes_wdata <= snes_wdata;
      end else if (w_done && (r_cur_master == MST_SNES)) begin
        r_snes_pend <= 1'b0;
      end
      if (w_mcu_accept) begin
        r_mcu_pend  <= 1'b1;
        r_mcu_we    <= mcu_we;
        r_mcu_addr  <= mcu_addr;
        r_mcu_wdata <= mcu_wdata;
      end else if (w_done && (r_cur_master == MST_MCU)) begin
        r_mcu_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cur_master <= MST_SNES;
      r_cur_we     <= 1'b0;
      r_cur_addr   <= '0;
      r_cur_wdata  <= '0;
      r_last_snes  <= 1'b0;
    end else if (w_grant) begin
      r_cur_master <= w_pick_mcu ? MST_MCU : MST_SNES;
      r_cur_we     <= w_sel_we;
      r_cur_addr   <= w_sel_addr;
      r_cur_wdata  <= w_sel_wdata;
      r_last_snes  <= !w_pick_mcu;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_snes_rdy   <= 1'b0;
      r_mcu_rdy    <= 1'b0;
      r_snes_rdata <= '0;
      r_mcu_rdata  <= '0;
    end else begin
      r_snes_rdy <= 1'b0;
      r_mcu_rdy  <= 1'b0;
      if (w_done) begin
        if (r_cur_master == MST_SNES) begin
          r_snes_rdy <= 1'b1;
          if (!r_cur_we) r_snes_rdata <= w_rd_byte;
        end else begin
          r_mcu_rdy <= 1'b1;
          if (!r_cur_we) r_mcu_rdata <= w_rd_byte;
        end
      end
`ifdef SNES_READ_CACHE_EN
      // Hit requires no SNES pending, so it never collides with a bus rdy.
      if (w_snes_hit) begin
        r_snes_rdy   <= 1'b1;
        r_snes_rdata <= w_cache_byte;
      end
`endif
    end
  end

  assign ROM_ADDR     = r_cur_addr[23:1];
  assign ROM_DATA_OUT = {r_cur_wdata, r_cur_wdata};
  assign snes_rdata   = r_snes_rdata;
  assign snes_rdy     = r_snes_rdy;
  assign snes_ovf     = r_snes_ovf;
  assign mcu_rdata    = r_mcu_rdata;
  assign mcu_rdy      = r_mcu_rdy;

endmodule

// File: tb/tb_rom_bus_sequencer.sv
// tb_rom_bus_sequencer
//   Directed bench for rom_bus_sequencer with default timing
//   (RD_CYCLES=4, WR_CYCLES=5, HOLD_CYCLES=1). The buffered-read steps are
//   included only when SNES_READ_CACHE_EN is defined.
module tb_rom_bus_sequencer;

  logic        CLK, RST_N;
  logic        snes_req, snes_we, mcu_req, mcu_we;
  logic [23:0] snes_addr, mcu_addr;
  logic [7:0]  snes_wdata, mcu_wdata, snes_rdata, mcu_rdata;
  logic        snes_rdy, snes_ovf, mcu_rdy;
  logic [22:0] ROM_ADDR;
  logic [15:0] ROM_DATA_IN, ROM_DATA_OUT;
  logic        ROM_DATA_OE, ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_a, cnt_b;

  rom_bus_sequencer dut (
    .CLK(CLK), .RST_N(RST_N),
    .snes_req(snes_req), .snes_we(snes_we), .snes_addr(snes_addr), .snes_wdata(snes_wdata),
    .snes_rdata(snes_rdata), .snes_rdy(snes_rdy), .snes_ovf(snes_ovf),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_rdata(mcu_rdata), .mcu_rdy(mcu_rdy),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA_IN(ROM_DATA_IN), .ROM_DATA_OUT(ROM_DATA_OUT),
    .ROM_DATA_OE(ROM_DATA_OE), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N),
    .ROM_WE_N(ROM_WE_N), .ROM_BHE_N(ROM_BHE_N), .ROM_BLE_N(ROM_BLE_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      $display("[TB] check %s obs=%0h exp=%0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    snes_req = 0; snes_we = 0; snes_addr = '0; snes_wdata = '0;
    mcu_req = 0; mcu_we = 0; mcu_addr = '0; mcu_wdata = '0;
    ROM_DATA_IN = '0;
    tick(); tick();

    // Reset state
    chk("rst_strobes", {ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N}, 32'h1f);
    chk("rst_oe_addr", {ROM_DATA_OE, ROM_ADDR}, 32'h0);
    chk("rst_outs", {snes_rdy, snes_ovf, mcu_rdy, snes_rdata, mcu_rdata}, 32'h0);
    RST_N = 1'b1;
    tick();

    // SNES read 0x000101, bus 0xA55A -> high byte 0xA5 at +6
    ROM_DATA_IN = 16'hA55A;
    snes_req = 1; snes_we = 0; snes_addr = 24'h000101;
    tick(); snes_req = 0;
    chk("rd_setup_ce_lanes", {ROM_CE_N, ROM_OE_N, ROM_BHE_N, ROM_BLE_N, ROM_DATA_OE}, 32'b01000);
    chk("rd_addr", ROM_ADDR, 32'h80);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rd_strobe%0d", k), {ROM_OE_N, ROM_WE_N, ROM_DATA_OE}, 32'b010);
    end
    tick();
    chk("rd_rdy", {snes_rdy, snes_rdata}, 32'h1A5);
    chk("rd_hold_strobes", {ROM_CE_N, ROM_OE_N}, 32'b11);
    tick();
    chk("rd_rdy_pulse", snes_rdy, 32'h0);

    // MCU write 0x000200 = 0x3C: low lane only, WE_N low 5 cycles
    mcu_req = 1; mcu_we = 1; mcu_addr = 24'h000200; mcu_wdata = 8'h3C;
    tick(); mcu_req = 0; mcu_we = 0;
    chk("wr_setup", {ROM_CE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N, ROM_DATA_OE}, 32'b01101);
    chk("wr_data", ROM_DATA_OUT, 32'h3C3C);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("wr_strobe%0d", k), {ROM_WE_N, ROM_OE_N, ROM_DATA_OE, ROM_BLE_N}, 32'b0110);
    end
    tick();
    chk("wr_rdy", {mcu_rdy, ROM_WE_N, ROM_DATA_OE}, 32'b110);
    tick();

    // Simultaneous requests: SNES 0x4 first, MCU 0x7 after HOLD
    ROM_DATA_IN = 16'h1234;
    snes_req = 1; snes_addr = 24'h000004;
    mcu_req = 1; mcu_addr = 24'h000007;
    tick(); snes_req = 0; mcu_req = 0;
    chk("sim_first_addr", ROM_ADDR, 32'h2);
    repeat (5) tick();
    chk("sim_snes_rdy", {snes_rdy, mcu_rdy, snes_rdata}, 32'h234);
    tick();
    chk("sim_idle_gap", ROM_CE_N, 32'h1);
    tick();
    chk("sim_mcu_setup", {ROM_CE_N, ROM_ADDR}, {9'h0, 23'h3});
    repeat (5) tick();
    chk("sim_mcu_rdy", {mcu_rdy, mcu_rdata}, 32'h112);
    tick();

    // Second SNES request before first rdy -> overflow, single rdy
    ROM_DATA_IN = 16'h00FF;
    cnt_a = 0; cnt_b = 0;
    snes_req = 1; snes_addr = 24'h000008;
    tick(); snes_req = 0;
    if (!ROM_CE_N) cnt_b++;
    snes_req = 1; snes_addr = 24'h000010;
    tick(); snes_req = 0;
    if (!ROM_CE_N) cnt_b++;
    chk("ovf_set", snes_ovf, 32'h1);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (snes_rdy) cnt_a++;
      if (!ROM_CE_N) cnt_b++;
    end
    chk("ovf_one_rdy", cnt_a, 32'd1);
    chk("ovf_one_cycle", cnt_b, 32'd5);
    chk("ovf_data_sticky", {snes_ovf, snes_rdata}, 32'h1FF);

    // Reset in the middle of STROBE
    snes_req = 1; snes_addr = 24'h000020;
    tick(); snes_req = 0;
    tick(); tick();
    chk("mid_in_strobe", ROM_OE_N, 32'h0);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_strobes", {ROM_CE_N, ROM_OE_N, ROM_WE_N}, 32'b111);
    chk("mid_rst_ovf", snes_ovf, 32'h0);
    tick(); tick();
    RST_N = 1'b1;
    cnt_a = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (snes_rdy || mcu_rdy) cnt_a++;
    end
    chk("mid_no_rdy", cnt_a, 32'd0);
    ROM_DATA_IN = 16'hBEEF;
    mcu_req = 1; mcu_we = 0; mcu_addr = 24'h000031;
    tick(); mcu_req = 0;
    repeat (5) tick();
    chk("post_rst_rd", {mcu_rdy, mcu_rdata}, 32'h1BE);
    tick();

`ifdef SNES_READ_CACHE_EN
    // Buffered reads: 0x10 fills, 0x11 hits next cycle without a bus cycle
    ROM_DATA_IN = 16'h7788;
    snes_req = 1; snes_we = 0; snes_addr = 24'h000010;
    tick(); snes_req = 0;
    repeat (5) tick();
    chk("c_fill", {snes_rdy, snes_rdata}, 32'h188);
    tick();
    ROM_DATA_IN = 16'h0000;
    snes_req = 1; snes_addr = 24'h000011;
    tick(); snes_req = 0;
    chk("c_hit", {snes_rdy, ROM_CE_N, snes_rdata}, 32'h377);
    mcu_req = 1; mcu_we = 1; mcu_addr = 24'h000011; mcu_wdata = 8'h5A;
    tick(); mcu_req = 0; mcu_we = 0;
    repeat (6) tick();
    chk("c_wr_rdy", mcu_rdy, 32'h1);
    tick();
    snes_req = 1; snes_addr = 24'h000011;
    tick(); snes_req = 0;
    chk("c_updated", {snes_rdy, ROM_CE_N, snes_rdata}, 32'h35A);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
